// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back always wins, and mul/div results wait in a 2-entry FIFO.
// Optional macro WB_ARB_BYPASS_EN lets an MD result go straight to the port when the FIFO is empty and the port is idle.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        WBwreg,
  input  logic [4:0]  WBwn,
  input  logic [31:0] WBdata,
  input  logic        MDreq,
  input  logic [4:0]  MDwn,
  input  logic [31:0] MDdata,
  output logic        MDack,
  output logic        rfWe,
  output logic [4:0]  rfWn,
  output logic [31:0] rfData,
  output logic        stall,
  output logic [1:0]  fifoCount
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  blk_q, blk_d;
  logic [1:0]  count_q, count_d;
  logic [4:0]  wn_q   [2];
  logic [4:0]  wn_d   [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];

  logic wb_act, fifo_empty, ack_raw, bypass, pop, push;
  logic squash0, squash1, keep0, keep1;

  assign wb_act     = WBwreg & (WBwn != 5'd0);
  assign fifo_empty = (count_q == 2'd0);
  assign ack_raw    = MDreq & (count_q != 2'd2);
  assign pop        = ~wb_act & ~fifo_empty;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = MDreq & (MDwn != 5'd0) & fifo_empty & ~wb_act;
`else
  assign bypass = 1'b0;
`endif

  // r0 results are acked and dropped; bypassed results never occupy a slot.
  assign push = ack_raw & (MDwn != 5'd0) & ~bypass;

  // A buffered result is stale once the pipeline overwrites the same register.
  assign squash0 = wb_act & (count_q != 2'd0) & (wn_q[0] == WBwn);
  assign squash1 = wb_act & (count_q == 2'd2) & (wn_q[1] == WBwn);
  assign keep0   = (count_q != 2'd0) & ~pop & ~squash0;
  assign keep1   = (count_q == 2'd2) & ~squash1;

  // Compact the survivors toward slot 0, then append the new result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wn_d    = wn_q;
    data_d  = data_q;
    count_d = 2'd0;
    if (keep0) begin
      count_d = 2'd1;
    end
    if (keep1) begin
      if (!keep0) begin
        wn_d[0]   = wn_q[1];
        data_d[0] = data_q[1];
      end
      count_d = count_d + 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) begin
        wn_d[0]   = MDwn;
        data_d[0] = MDdata;
      end else begin
        wn_d[1]   = MDwn;
        data_d[1] = MDdata;
      end
      count_d = count_d + 2'd1;
    end
  end

  // The counter also clears when the FIFO drains, so a later backlog starts counting from zero.
  always_comb begin
    blk_d = blk_q;
    if (pop || (count_d == 2'd0)) begin
      blk_d = 4'd0;
    end else if ((state_q == ST_WAIT) && !fifo_empty && wb_act && (blk_q < LIMIT)) begin
      blk_d = blk_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d != 2'd0) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (count_d == 2'd0)     state_d = ST_IDLE;
        else if (blk_d >= LIMIT) state_d = ST_FORCE;
      end
      ST_FORCE: begin
        if (count_d == 2'd0) state_d = ST_IDLE;
        else if (pop)        state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      blk_q   <= 4'd0;
      count_q <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      blk_q   <= blk_d;
      count_q <= count_d;
    end
  end

  // NOTE: the payload storage is not reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    wn_q   <= wn_d;
    data_q <= data_d;
  end

  always_comb begin
    rfWe   = 1'b0;
    rfWn   = 5'd0;
    rfData = 32'd0;
    if (clrn) begin
      if (wb_act) begin
        rfWe   = 1'b1;
        rfWn   = WBwn;
        rfData = WBdata;
      end else if (!fifo_empty) begin
        rfWe   = 1'b1;
        rfWn   = wn_q[0];
        rfData = data_q[0];
      end else if (bypass) begin
        rfWe   = 1'b1;
        rfWn   = MDwn;
        rfData = MDdata;
      end
    end
  end

  assign MDack     = clrn & ack_raw;
  assign stall     = (state_q == ST_FORCE);
  assign fifoCount = count_q;

endmodule
